// File: rtl/write_buffer_pkg.sv
// Shared configuration for the write buffer: default depth, read-FSM state
// encodings and the word-granularity address compare.
package write_buffer_pkg;

    // Default number of buffered write entries (power of two, 2..16).
    localparam int unsigned WB_DEPTH = 4;

    // Read-path FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFwd    = 2'd1,
        StMemReq = 2'd2,
        StResp   = 2'd3
    } rd_state_e;

    // Two byte addresses refer to the same 32-bit word when bits [31:2] agree.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/write_buffer_wb_fifo.sv
// Circular FIFO of {addr, data} write entries with a youngest-match search
// across all occupied slots, used for store-to-load forwarding.
module wb_fifo
    import write_buffer_pkg::*;
#(
    parameter int unsigned Depth = WB_DEPTH,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // Push side; a push while full is dropped.
    input  logic            push_i,
    input  logic [31:0]     push_addr_i,
    input  logic [31:0]     push_data_i,
    // Pop side; a pop while empty is dropped.
    input  logic            pop_i,
    output logic [31:0]     head_addr_o,
    output logic [31:0]     head_data_o,
    output logic [CntW-1:0] count_o,
    // Youngest-match lookup over occupied entries.
    input  logic [31:0]     search_addr_i,
    output logic            hit_o,
    output logic [31:0]     hit_data_o
);

    logic [31:0]     addr_q [Depth];
    logic [31:0]     addr_d [Depth];
    logic [31:0]     data_q [Depth];
    logic [31:0]     data_d [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push_i && (count_q != CntW'(Depth));
    assign pop_ok  = pop_i && (count_q != '0);

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            addr_d[tail_q] = push_addr_i;
            data_d[tail_q] = push_data_i;
            // Depth is a power of two, so pointer overflow is the wrap.
            tail_d         = tail_q + 1'b1;
        end
        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; contents are discarded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    // The head entry stays searchable in the cycle it pops.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx        = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && word_match(addr_q[idx], search_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the Cache (cm_*) and DataMemory (mem_*). Write-backs
// are queued and drained one per cycle; refill reads are forwarded from the
// youngest matching queued write or sent on to DataMemory.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic        CLK,
    input  logic        Reset,
    // Cache write-back request.
    input  logic        cm_WriteValid,
    input  logic [31:0] cm_WriteAddr,
    input  logic [31:0] cm_WriteData,
    output logic        cm_WriteReady,
    // Cache refill request / response.
    input  logic        cm_ReadValid,
    input  logic [31:0] cm_ReadAddr,
    output logic        cm_ReadReady,
    output logic [31:0] cm_ReadData,
    // Drain path to DataMemory.
    output logic        mem_WriteValid,
    output logic [31:0] mem_WriteAddr,
    output logic [31:0] mem_WriteData,
    // DataMemory read path.
    output logic        mem_ReadValid,
    output logic [31:0] mem_ReadAddr,
    input  logic        mem_ReadReady,
    input  logic [31:0] mem_ReadData
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [CntW-1:0] fifo_count;
    logic [31:0]     head_addr;
    logic [31:0]     head_data;
    logic            fifo_hit;
    logic [31:0]     fifo_hit_data;
    logic            drain;
    logic            wr_fire;

    rd_state_e   state_q, state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    // No pop bypass: readiness depends only on the registered count.
    assign cm_WriteReady = (fifo_count < CntW'(DEPTH));
    assign wr_fire       = cm_WriteValid && cm_WriteReady;

    // DataMemory always accepts, so the head drains whenever it is valid.
    assign drain          = (fifo_count != '0);
    assign mem_WriteValid = drain;
    assign mem_WriteAddr  = drain ? head_addr : '0;
    assign mem_WriteData  = drain ? head_data : '0;

    wb_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i         (CLK),
        .rst_i         (Reset),
        .push_i        (cm_WriteValid),
        .push_addr_i   (cm_WriteAddr),
        .push_data_i   (cm_WriteData),
        .pop_i         (drain),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .count_o       (fifo_count),
        .search_addr_i (cm_ReadAddr),
        .hit_o         (fifo_hit),
        .hit_data_o    (fifo_hit_data)
    );

    // Read FSM next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        cm_ReadReady  = 1'b0;
        mem_ReadValid = 1'b0;
        case (state_q)
            StIdle: begin
                if (cm_ReadValid) begin
                    // A write accepted this cycle is younger than anything stored.
                    if (wr_fire && word_match(cm_WriteAddr, cm_ReadAddr)) begin
                        state_d   = StFwd;
                        rd_data_d = cm_WriteData;
                    end else if (fifo_hit) begin
                        state_d   = StFwd;
                        rd_data_d = fifo_hit_data;
                    end else begin
                        state_d   = StMemReq;
                        rd_addr_d = cm_ReadAddr;
                    end
                end
            end
            StFwd: begin
                cm_ReadReady = 1'b1;
                state_d      = StIdle;
            end
            StMemReq: begin
                mem_ReadValid = 1'b1;
                if (mem_ReadReady) begin
                    rd_data_d = mem_ReadData;
                    state_d   = StResp;
                end
            end
            StResp: begin
                cm_ReadReady = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read FSM state and latched address/data.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Address/data buses read as zero when their valid is low.
    assign cm_ReadData  = cm_ReadReady ? rd_data_q : '0;
    assign mem_ReadAddr = mem_ReadValid ? rd_addr_q : '0;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: directed stimulus pushes expected drain
// writes and read responses into queues; a negedge monitor pops and compares
// whenever the DUT presents mem_WriteValid or cm_ReadReady.
module tb_write_buffer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cm_WriteValid;
    logic [31:0] cm_WriteAddr;
    logic [31:0] cm_WriteData;
    logic        cm_WriteReady;
    logic        cm_ReadValid;
    logic [31:0] cm_ReadAddr;
    logic        cm_ReadReady;
    logic [31:0] cm_ReadData;
    logic        mem_WriteValid;
    logic [31:0] mem_WriteAddr;
    logic [31:0] mem_WriteData;
    logic        mem_ReadValid;
    logic [31:0] mem_ReadAddr;
    logic        mem_ReadReady;
    logic [31:0] mem_ReadData;

    always #5 CLK = ~CLK;

    write_buffer #(
        .DEPTH (4)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .cm_WriteValid  (cm_WriteValid),
        .cm_WriteAddr   (cm_WriteAddr),
        .cm_WriteData   (cm_WriteData),
        .cm_WriteReady  (cm_WriteReady),
        .cm_ReadValid   (cm_ReadValid),
        .cm_ReadAddr    (cm_ReadAddr),
        .cm_ReadReady   (cm_ReadReady),
        .cm_ReadData    (cm_ReadData),
        .mem_WriteValid (mem_WriteValid),
        .mem_WriteAddr  (mem_WriteAddr),
        .mem_WriteData  (mem_WriteData),
        .mem_ReadValid  (mem_ReadValid),
        .mem_ReadAddr   (mem_ReadAddr),
        .mem_ReadReady  (mem_ReadReady),
        .mem_ReadData   (mem_ReadData)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    wr_t         mon_wr;
    logic [31:0] mon_rd;
    int          n_checks = 0;
    int          n_pass = 0;
    int          rd_req_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare every presented drain write and read response.
    always @(negedge CLK) begin
        if (!Reset) begin
            if (mem_ReadValid) rd_req_cycles++;
            if (mem_WriteValid) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got drain of 0x%08h, expected none",
                             mem_WriteAddr);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check("drain_addr", mem_WriteAddr, mon_wr.a);
                    check("drain_data", mem_WriteData, mon_wr.d);
                end
            end
            if (cm_ReadReady) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got response 0x%08h, expected none",
                             cm_ReadData);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    check("read_data", cm_ReadData, mon_rd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        cm_WriteValid = 1'b0;
        cm_WriteAddr  = '0;
        cm_WriteData  = '0;
        cm_ReadValid  = 1'b0;
        cm_ReadAddr   = '0;
        mem_ReadReady = 1'b0;
        mem_ReadData  = '0;
        tick();
        tick();

        // Reset state.
        @(negedge CLK);
        check("rst_wready", cm_WriteReady, 1);
        check("rst_rready", cm_ReadReady, 0);
        check("rst_rdata", cm_ReadData, 0);
        check("rst_mwvalid", mem_WriteValid, 0);
        check("rst_mwaddr", mem_WriteAddr, 0);
        check("rst_mwdata", mem_WriteData, 0);
        check("rst_mrvalid", mem_ReadValid, 0);
        check("rst_mraddr", mem_ReadAddr, 0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        // Fill: five back-to-back writes while draining.
        for (int i = 0; i < 5; i++) begin
            cm_WriteValid = 1'b1;
            cm_WriteAddr  = 32'h0000_1000 + 32'(4 * i);
            cm_WriteData  = 32'hD000_0000 + 32'(i);
            exp_wr.push_back({cm_WriteAddr, cm_WriteData});
            @(negedge CLK);
            check("fill_wready", cm_WriteReady, 1);
            @(posedge CLK);
            #1;
        end
        cm_WriteValid = 1'b0;
        repeat (3) tick();
        check("fill_drained", exp_wr.size(), 0);

        // Full: drain held off, four writes fill, fifth is dropped.
        force dut.drain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cm_WriteValid = 1'b1;
            cm_WriteAddr  = 32'h0000_2000 + 32'(4 * i);
            cm_WriteData  = 32'hF000_0000 + 32'(i);
            exp_wr.push_back({cm_WriteAddr, cm_WriteData});
            tick();
        end
        cm_WriteAddr = 32'h0000_2FF0;
        cm_WriteData = 32'h0000_DEAD;
        @(negedge CLK);
        check("full_wready", cm_WriteReady, 0);
        check("full_count", 32'(dut.u_fifo.count_o), 4);
        @(posedge CLK);
        #1;
        cm_WriteValid = 1'b0;
        @(negedge CLK);
        check("full_count_after", 32'(dut.u_fifo.count_o), 4);
        @(posedge CLK);
        #1;
        release dut.drain;
        repeat (6) tick();
        check("full_drained", exp_wr.size(), 0);

        // Forward: two writes to 0x100, read next cycle gets the younger one.
        rd_req_cycles = 0;
        cm_WriteValid = 1'b1;
        cm_WriteAddr  = 32'h0000_0100;
        cm_WriteData  = 32'h0000_AAAA;
        exp_wr.push_back({cm_WriteAddr, cm_WriteData});
        tick();
        cm_WriteData = 32'h0000_BBBB;
        exp_wr.push_back({cm_WriteAddr, cm_WriteData});
        tick();
        cm_WriteValid = 1'b0;
        cm_ReadValid  = 1'b1;
        cm_ReadAddr   = 32'h0000_0100;
        exp_rd.push_back(32'h0000_BBBB);
        tick();
        @(negedge CLK);
        check("fwd_latency", cm_ReadReady, 1);
        @(posedge CLK);
        #1;
        cm_ReadValid = 1'b0;
        @(negedge CLK);
        check("fwd_one_pulse", cm_ReadReady, 0);
        repeat (2) tick();
        check("fwd_no_memread", rd_req_cycles, 0);

        // Same-cycle write and read of 0x300.
        cm_WriteValid = 1'b1;
        cm_WriteAddr  = 32'h0000_0300;
        cm_WriteData  = 32'h0000_0055;
        exp_wr.push_back({cm_WriteAddr, cm_WriteData});
        cm_ReadValid  = 1'b1;
        cm_ReadAddr   = 32'h0000_0300;
        exp_rd.push_back(32'h0000_0055);
        tick();
        cm_WriteValid = 1'b0;
        @(negedge CLK);
        check("same_cycle_ready", cm_ReadReady, 1);
        @(posedge CLK);
        #1;
        cm_ReadValid = 1'b0;
        tick();
        check("same_cycle_no_memread", rd_req_cycles, 0);

        // Word granularity: write 0x400, read byte address 0x403 hits.
        cm_WriteValid = 1'b1;
        cm_WriteAddr  = 32'h0000_0400;
        cm_WriteData  = 32'h0000_0077;
        exp_wr.push_back({cm_WriteAddr, cm_WriteData});
        tick();
        cm_WriteValid = 1'b0;
        cm_ReadValid  = 1'b1;
        cm_ReadAddr   = 32'h0000_0403;
        exp_rd.push_back(32'h0000_0077);
        tick();
        @(negedge CLK);
        check("word_hit_ready", cm_ReadReady, 1);
        @(posedge CLK);
        #1;
        cm_ReadValid = 1'b0;
        tick();
        check("word_no_memread", rd_req_cycles, 0);

        // Miss: read 0x200, memory answers in the third request cycle.
        cm_ReadValid = 1'b1;
        cm_ReadAddr  = 32'h0000_0200;
        exp_rd.push_back(32'h0000_1234);
        tick();
        @(negedge CLK);
        check("miss_mrvalid", mem_ReadValid, 1);
        check("miss_mraddr", mem_ReadAddr, 32'h0000_0200);
        check("miss_no_early_ready", cm_ReadReady, 0);
        @(posedge CLK);
        #1;
        tick();
        mem_ReadReady = 1'b1;
        mem_ReadData  = 32'h0000_1234;
        @(negedge CLK);
        check("miss_wait_ready", cm_ReadReady, 0);
        @(posedge CLK);
        #1;
        mem_ReadReady = 1'b0;
        mem_ReadData  = '0;
        @(negedge CLK);
        check("miss_resp_ready", cm_ReadReady, 1);
        check("miss_mrvalid_drop", mem_ReadValid, 0);
        @(posedge CLK);
        #1;
        cm_ReadValid = 1'b0;
        tick();
        check("miss_req_cycles", rd_req_cycles, 3);

        // Reset while in MEM_REQ with buffered writes pending.
        force dut.drain = 1'b0;
        cm_WriteValid = 1'b1;
        cm_WriteAddr  = 32'h0000_0600;
        cm_WriteData  = 32'h0000_0066;
        tick();
        cm_WriteAddr = 32'h0000_0604;
        tick();
        cm_WriteValid = 1'b0;
        cm_ReadValid  = 1'b1;
        cm_ReadAddr   = 32'h0000_0700;
        tick();
        cm_ReadValid = 1'b0;
        @(negedge CLK);
        check("rstreq_mrvalid", mem_ReadValid, 1);
        check("rstreq_count", 32'(dut.u_fifo.count_o), 2);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        release dut.drain;
        @(negedge CLK);
        check("rstreq_mrvalid_drop", mem_ReadValid, 0);
        check("rstreq_mwvalid", mem_WriteValid, 0);
        check("rstreq_wready", cm_WriteReady, 1);
        check("rstreq_count_clear", 32'(dut.u_fifo.count_o), 0);
        @(posedge CLK);
        #1;
        mem_ReadReady = 1'b1;
        mem_ReadData  = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("late_ready_ignored", cm_ReadReady, 0);
            @(posedge CLK);
            #1;
        end
        mem_ReadReady = 1'b0;
        mem_ReadData  = '0;
        repeat (2) tick();

        check("end_wr_queue", exp_wr.size(), 0);
        check("end_rd_queue", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
